snoop_bus_controller: RTL and testbench
=======================================

Name: snoop_bus_controller

Overview:
- Shared-bus stage directly downstream of the per-processor MSI cache controllers.
- Arbitrates the caches' bus requests (read miss, write miss, invalidate) and broadcasts the winner to all snoopers.
- Collects owner (M-state) snoop data and performs victim and owner writebacks into its internal main memory.
- Returns fill data to the requester and pulses done_next once per completed transaction.

Parameters:
- NPROC, 3, number of cache controllers on the bus.
- TAG_W, 5, address/tag width; memory depth is 2**TAG_W.
- DATA_W, 7, data word width.
- MEM_LAT, 2, memory read/write latency in cycles (minimum 1).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NPROC  per-cache bus request.
- req_cmd  in  2*NPROC  per-cache command: 01 read miss, 10 write miss, 11 invalidate.
- req_tag  in  TAG_W*NPROC  per-cache block address.
- wb_valid  in  NPROC  the requester's victim line is M and must be written back first.
- wb_tag  in  TAG_W*NPROC  victim address.
- wb_data  in  DATA_W*NPROC  victim data.
- gnt  out  NPROC  one-hot grant, held for the whole transaction.
- bus_valid  out  1  one-cycle broadcast strobe.
- bus_cmd  out  2  broadcast command.
- bus_tag  out  TAG_W  broadcast address.
- bus_src  out  NPROC  one-hot originator of the broadcast.
- snp_hit_m  in  NPROC  snooper holds bus_tag in M; valid the cycle after bus_valid.
- snp_data  in  DATA_W*NPROC  snooper data, qualified by snp_hit_m.
- rsp_valid  out  1  one-cycle fill strobe to the cache selected by gnt.
- rsp_data  out  DATA_W  fill data.
- done_next  out  1  one-cycle pulse at transaction completion.
- mem_we  out  1  debug: memory write occurring this cycle.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, round-robin pointer set to cache 0. Reset mid-transaction aborts the transaction without completing it. Memory contents are not reset; they are preloaded hierarchically by the testbench.
- Eligibility: a cache is eligible when req_valid=1 and req_cmd != 00.
- Arbitration: round-robin starting from the pointer. After a completed transaction the pointer moves to winner+1 mod NPROC.
- FSM states: IDLE, WB, BCAST, SNOOP, OWN_WB, MEM_RD, RSP.
- IDLE:
  - If any cache is eligible, latch the winner's cmd, tag and wb fields and assert gnt on the next edge.
  - Next state is WB if the latched wb_valid=1, otherwise BCAST.
- WB: mem_we=1 for MEM_LAT cycles; memory[wb_tag] is written with wb_data on the final cycle. Next state BCAST.
- BCAST: one cycle with bus_valid=1 and bus_cmd/bus_tag/bus_src driven. Next state SNOOP.
- SNOOP: sample snp_hit_m with the requester's own bit masked off.
  - cmd=11 (invalidate): go to RSP with no rsp_valid; only done_next pulses.
  - Exactly one owner: capture its snp_data and go to OWN_WB.
  - More than one owner: use the lowest index, set proto_err, go to OWN_WB.
  - No owner: go to MEM_RD.
- OWN_WB: mem_we=1 for MEM_LAT cycles, writing memory[tag] with the owner data. Fill data = owner data. Next state RSP.
- MEM_RD: MEM_LAT cycles; fill data = memory[tag]. Next state RSP.
- RSP:
  - For read miss and write miss: rsp_valid=1 and rsp_data = fill data.
  - For all commands: done_next=1.
  - gnt drops on the next edge, the pointer advances, next state IDLE.
- Latency, read miss, no wb, no owner, MEM_LAT=2: request seen in IDLE at cycle N; gnt and BCAST at N+1; SNOOP at N+2; MEM_RD at N+3..N+4; rsp_valid and done_next at N+5. IDLE again at N+6, so back-to-back grants are at least 6 cycles apart.
- Each WB or OWN_WB phase adds MEM_LAT cycles.
- req_valid deasserting after grant is ignored; the transaction completes.
- Requests are not re-sampled until IDLE.
- Write-miss data merge is done in the cache; this block never writes requester store data to memory.

Decomposition:
- Package snoop_bus_pkg holds:
  - command constants CMD_NONE=00, CMD_RDMISS=01, CMD_WRMISS=10, CMD_INV=11;
  - MSI state constants I=00, S=01, M=10;
  - the FSM state enumeration;
  - TAG_W/DATA_W defaults.
- One sub-module, rr_arbiter (NPROC-wide round-robin, one-hot grant, pointer advance input). The memory array stays inline.

Test Plan:
- Memory[8]=5, P1 read miss tag 8, no owner -> gnt=010, bus_cmd=01, rsp_valid with rsp_data=5 at N+5, done_next pulse, mem_we never asserted.
- P0 write miss tag 10 while P3 has snp_hit_m=1 with snp_data=30 -> OWN_WB writes memory[10]=30, rsp_data=30, proto_err=0.
- P3 read miss tag 28 with wb_valid, wb_tag=20, wb_data=20 -> WB phase first, memory[20]=20, then BCAST with tag 28; total latency N+7.
- P0, P1 and P3 request simultaneously after reset -> grant order P0, P1, P3 across three transactions, one done_next per transaction.
- P1 invalidate tag 0 -> one bus_valid with cmd 11, no rsp_valid, done_next pulses 2 cycles after gnt.
- Two snoopers assert snp_hit_m -> lowest index data used, proto_err set and held; reset asserted mid-MEM_RD -> all outputs 0 immediately, proto_err cleared, memory unchanged.

Source files
------------

// File: rtl/snoop_bus_pkg.sv
// Shared definitions for the snooping bus controller: bus commands, MSI line
// states, controller FSM states and default widths.
package snoop_bus_pkg;

    localparam logic [1:0] CMD_NONE   = 2'b00;
    localparam logic [1:0] CMD_RDMISS = 2'b01;
    localparam logic [1:0] CMD_WRMISS = 2'b10;
    localparam logic [1:0] CMD_INV    = 2'b11;

    localparam logic [1:0] I = 2'b00;
    localparam logic [1:0] S = 2'b01;
    localparam logic [1:0] M = 2'b10;

    localparam int unsigned TAG_W_DEF  = 5;
    localparam int unsigned DATA_W_DEF = 7;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        BCAST,
        SNOOP,
        OWN_WB,
        MEM_RD,
        RSP
    } state_e;

endpackage

// File: rtl/snoop_bus_controller_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant searched from the pointer upward,
// pointer moves past the completed winner when adv is pulsed.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         adv,
    input  logic [N-1:0] adv_gnt,
    output logic [N-1:0] gnt
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        // First pass covers indices at/above the pointer, second pass wraps.
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i] && (PTR_W'(i) >= ptr_q)) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i] && (PTR_W'(i) < ptr_q)) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end

        ptr_d = ptr_q;
        if (adv) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (adv_gnt[i]) begin
                    ptr_d = (i + 1 == N) ? '0 : PTR_W'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/snoop_bus_controller.sv
// Shared snooping bus stage behind the MSI caches: arbitrates misses and
// invalidates, broadcasts them, handles victim/owner writebacks and fills.
module snoop_bus_controller
    import snoop_bus_pkg::*;
#(
    parameter int unsigned NPROC   = 3,
    parameter int unsigned TAG_W   = TAG_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NPROC-1:0]        req_valid,
    input  logic [2*NPROC-1:0]      req_cmd,
    input  logic [TAG_W*NPROC-1:0]  req_tag,
    input  logic [NPROC-1:0]        wb_valid,
    input  logic [TAG_W*NPROC-1:0]  wb_tag,
    input  logic [DATA_W*NPROC-1:0] wb_data,
    output logic [NPROC-1:0]        gnt,
    output logic                    bus_valid,
    output logic [1:0]              bus_cmd,
    output logic [TAG_W-1:0]        bus_tag,
    output logic [NPROC-1:0]        bus_src,
    input  logic [NPROC-1:0]        snp_hit_m,
    input  logic [DATA_W*NPROC-1:0] snp_data,
    output logic                    rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    done_next,
    output logic                    mem_we,
    output logic                    proto_err
);

    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_e              state_q, state_d;
    logic [NPROC-1:0]    gnt_q, gnt_d;
    logic [1:0]          cmd_q, cmd_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [TAG_W-1:0]    wb_tag_q, wb_tag_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                proto_err_q, proto_err_d;

    logic [DATA_W-1:0]   mem_q [2**TAG_W];
    logic                mem_wr_en;
    logic [TAG_W-1:0]    mem_wr_addr;
    logic [DATA_W-1:0]   mem_wr_data;

    logic [NPROC-1:0]    eligible;
    logic [NPROC-1:0]    arb_gnt;
    logic [NPROC-1:0]    hits;
    logic                go_wb;
    logic                own_found;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NPROC; i++) begin
            eligible[i] = req_valid[i] && (req_cmd[2*i +: 2] != CMD_NONE);
        end
    end

    rr_arbiter #(.N(NPROC)) u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (eligible),
        .adv     (state_q == RSP),
        .adv_gnt (gnt_q),
        .gnt     (arb_gnt)
    );

    assign hits = snp_hit_m & ~gnt_q;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        cmd_d       = cmd_q;
        tag_d       = tag_q;
        wb_tag_d    = wb_tag_q;
        wb_data_d   = wb_data_q;
        fill_d      = fill_q;
        cnt_d       = cnt_q;
        proto_err_d = proto_err_q;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mem_we      = 1'b0;
        bus_valid   = 1'b0;
        rsp_valid   = 1'b0;
        done_next   = 1'b0;
        go_wb       = 1'b0;
        own_found   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                for (int unsigned i = 0; i < NPROC; i++) begin
                    if (arb_gnt[i]) begin
                        cmd_d     = req_cmd[2*i +: 2];
                        tag_d     = req_tag[i*TAG_W +: TAG_W];
                        wb_tag_d  = wb_tag[i*TAG_W +: TAG_W];
                        wb_data_d = wb_data[i*DATA_W +: DATA_W];
                        go_wb     = wb_valid[i];
                    end
                end
                if (|arb_gnt) begin
                    gnt_d   = arb_gnt;
                    state_d = go_wb ? WB : BCAST;
                end
            end
            WB: begin
                mem_we = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_addr = wb_tag_q;
                    mem_wr_data = wb_data_q;
                    cnt_d       = '0;
                    state_d     = BCAST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BCAST: begin
                bus_valid = 1'b1;
                state_d   = SNOOP;
            end
            SNOOP: begin
                if (cmd_q == CMD_INV) begin
                    state_d = RSP;
                end else if (|hits) begin
                    for (int unsigned i = 0; i < NPROC; i++) begin
                        if (!own_found && hits[i]) begin
                            own_found = 1'b1;
                            fill_d    = snp_data[i*DATA_W +: DATA_W];
                        end
                    end
                    // More than one bit set means two caches claim M.
                    if ((hits & (hits - 1'b1)) != '0) begin
                        proto_err_d = 1'b1;
                    end
                    state_d = OWN_WB;
                end else begin
                    state_d = MEM_RD;
                end
            end
            OWN_WB: begin
                mem_we = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_addr = tag_q;
                    mem_wr_data = fill_q;
                    cnt_d       = '0;
                    state_d     = RSP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MEM_RD: begin
                if (cnt_q == CNT_LAST) begin
                    fill_d  = mem_q[tag_q];
                    cnt_d   = '0;
                    state_d = RSP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RSP: begin
                rsp_valid = (cmd_q != CMD_INV);
                done_next = 1'b1;
                gnt_d     = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            cmd_q       <= '0;
            tag_q       <= '0;
            wb_tag_q    <= '0;
            wb_data_q   <= '0;
            fill_q      <= '0;
            cnt_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            cmd_q       <= cmd_d;
            tag_q       <= tag_d;
            wb_tag_q    <= wb_tag_d;
            wb_data_q   <= wb_data_d;
            fill_q      <= fill_d;
            cnt_q       <= cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Memory contents survive reset; only the write port is clocked here.
    always_ff @(posedge clock) begin
        if (mem_wr_en) begin
            mem_q[mem_wr_addr] <= mem_wr_data;
        end
    end

    assign gnt       = gnt_q;
    assign bus_cmd   = bus_valid ? cmd_q : '0;
    assign bus_tag   = bus_valid ? tag_q : '0;
    assign bus_src   = bus_valid ? gnt_q : '0;
    assign rsp_data  = rsp_valid ? fill_q : '0;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_snoop_bus_controller.sv
// Directed bench for snoop_bus_controller with four caches on the bus,
// memory preloaded hierarchically.
module tb_snoop_bus_controller;

    localparam int unsigned NP = 4;
    localparam int unsigned TW = 5;
    localparam int unsigned DW = 7;

    logic              clock;
    logic              reset;
    logic [NP-1:0]     req_valid;
    logic [2*NP-1:0]   req_cmd;
    logic [TW*NP-1:0]  req_tag;
    logic [NP-1:0]     wb_valid;
    logic [TW*NP-1:0]  wb_tag;
    logic [DW*NP-1:0]  wb_data;
    logic [NP-1:0]     gnt;
    logic              bus_valid;
    logic [1:0]        bus_cmd;
    logic [TW-1:0]     bus_tag;
    logic [NP-1:0]     bus_src;
    logic [NP-1:0]     snp_hit_m;
    logic [DW*NP-1:0]  snp_data;
    logic              rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              done_next;
    logic              mem_we;
    logic              proto_err;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    int            w_cyc, w_we, w_bv, w_rsp;
    logic [NP-1:0] w_win, w_bsrc;
    logic [1:0]    w_bcmd;
    logic [TW-1:0] w_btag;
    logic [DW-1:0] w_rdata;

    snoop_bus_controller #(
        .NPROC   (NP),
        .TAG_W   (TW),
        .DATA_W  (DW),
        .MEM_LAT (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_cmd   (req_cmd),
        .req_tag   (req_tag),
        .wb_valid  (wb_valid),
        .wb_tag    (wb_tag),
        .wb_data   (wb_data),
        .gnt       (gnt),
        .bus_valid (bus_valid),
        .bus_cmd   (bus_cmd),
        .bus_tag   (bus_tag),
        .bus_src   (bus_src),
        .snp_hit_m (snp_hit_m),
        .snp_data  (snp_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .done_next (done_next),
        .mem_we    (mem_we),
        .proto_err (proto_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (done_next) done_cnt++;
    end

    task automatic clear_inputs();
        req_valid = '0; req_cmd = '0; req_tag = '0;
        wb_valid = '0; wb_tag = '0; wb_data = '0;
        snp_hit_m = '0; snp_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic set_req(input int p, input logic [1:0] cmd, input logic [TW-1:0] tag);
        req_valid[p] = 1'b1;
        req_cmd[2*p +: 2] = cmd;
        req_tag[p*TW +: TW] = tag;
    endtask

    // Steps cycles until done_next (bounded), recording what the bus did.
    task automatic wait_done(input bit clr);
        w_cyc = -1; w_we = 0; w_bv = 0; w_rsp = 0;
        w_win = '0; w_bsrc = '0; w_bcmd = '0; w_btag = '0; w_rdata = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock); #1;
            if (clr && c == 1) req_valid = '0;
            if (w_win == '0) w_win = gnt;
            if (mem_we) w_we++;
            if (bus_valid) begin
                w_bv++; w_bcmd = bus_cmd; w_btag = bus_tag; w_bsrc = bus_src;
            end
            if (rsp_valid) begin
                w_rsp++; w_rdata = rsp_data;
            end
            if (done_next) begin
                w_cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        @(posedge clock); #1;
        checks++;
        if ({gnt, bus_valid, bus_cmd, bus_tag, bus_src, rsp_valid, rsp_data, done_next, mem_we, proto_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: gnt=%b bv=%b rv=%b done=%b we=%b perr=%b expected all zero", gnt, bus_valid, rsp_valid, done_next, mem_we, proto_err);
        end
        reset = 1'b0;
    endtask

    task automatic test_read_miss();
        do_reset();
        dut.mem_q[8] = 7'd5;
        set_req(1, 2'b01, 5'd8);
        wait_done(1'b1);
        checks++; if (w_win !== 4'b0010) begin failures++; $display("FAIL rd_gnt: got %b expected 0010", w_win); end
        checks++; if (w_bcmd !== 2'b01) begin failures++; $display("FAIL rd_bus_cmd: got %b expected 01", w_bcmd); end
        checks++; if (w_btag !== 5'd8 || w_bsrc !== 4'b0010) begin failures++; $display("FAIL rd_bus_tag_src: got tag %0d src %b expected 8 0010", w_btag, w_bsrc); end
        checks++; if (w_cyc !== 5) begin failures++; $display("FAIL rd_latency: got %0d expected 5", w_cyc); end
        checks++; if (w_rsp !== 1 || w_rdata !== 7'd5) begin failures++; $display("FAIL rd_rsp: got n=%0d data=%0d expected 1 5", w_rsp, w_rdata); end
        checks++; if (w_we !== 0) begin failures++; $display("FAIL rd_no_mem_we: got %0d expected 0", w_we); end
        @(posedge clock); #1;
        checks++; if (gnt !== 4'b0000 || done_next !== 1'b0) begin failures++; $display("FAIL rd_release: got gnt=%b done=%b expected 0000 0", gnt, done_next); end
    endtask

    task automatic test_owner_wb();
        do_reset();
        dut.mem_q[10] = 7'd0;
        set_req(0, 2'b10, 5'd10);
        snp_hit_m = 4'b1001;
        snp_data[3*DW +: DW] = 7'd30;
        snp_data[0 +: DW]    = 7'd99;
        wait_done(1'b1);
        snp_hit_m = '0;
        checks++; if (w_win !== 4'b0001) begin failures++; $display("FAIL own_gnt: got %b expected 0001", w_win); end
        checks++; if (w_rdata !== 7'd30) begin failures++; $display("FAIL own_rsp_data: got %0d expected 30", w_rdata); end
        checks++; if (w_cyc !== 5 || w_we !== 2) begin failures++; $display("FAIL own_timing: got cyc=%0d we=%0d expected 5 2", w_cyc, w_we); end
        checks++; if (dut.mem_q[10] !== 7'd30) begin failures++; $display("FAIL own_mem: got %0d expected 30", dut.mem_q[10]); end
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL own_proto_err: got %b expected 0", proto_err); end
    endtask

    task automatic test_victim_wb();
        do_reset();
        dut.mem_q[28] = 7'd17;
        dut.mem_q[20] = 7'd0;
        set_req(3, 2'b01, 5'd28);
        wb_valid[3] = 1'b1;
        wb_tag[3*TW +: TW]  = 5'd20;
        wb_data[3*DW +: DW] = 7'd20;
        wait_done(1'b1);
        wb_valid = '0;
        checks++; if (w_win !== 4'b1000) begin failures++; $display("FAIL wb_gnt: got %b expected 1000", w_win); end
        checks++; if (w_cyc !== 7) begin failures++; $display("FAIL wb_latency: got %0d expected 7", w_cyc); end
        checks++; if (w_we !== 2 || w_bv !== 1 || w_btag !== 5'd28) begin failures++; $display("FAIL wb_phases: got we=%0d bv=%0d tag=%0d expected 2 1 28", w_we, w_bv, w_btag); end
        checks++; if (dut.mem_q[20] !== 7'd20) begin failures++; $display("FAIL wb_mem: got %0d expected 20", dut.mem_q[20]); end
        checks++; if (w_rdata !== 7'd17) begin failures++; $display("FAIL wb_fill: got %0d expected 17", w_rdata); end
    endtask

    task automatic test_round_robin();
        int d0;
        do_reset();
        dut.mem_q[1] = 7'd41; dut.mem_q[2] = 7'd42; dut.mem_q[3] = 7'd43;
        set_req(0, 2'b01, 5'd1);
        set_req(1, 2'b01, 5'd2);
        set_req(3, 2'b01, 5'd3);
        d0 = done_cnt;
        wait_done(1'b0);
        req_valid[0] = 1'b0;
        checks++; if (w_win !== 4'b0001 || w_rdata !== 7'd41) begin failures++; $display("FAIL rr_first: got %b data %0d expected 0001 41", w_win, w_rdata); end
        wait_done(1'b0);
        req_valid[1] = 1'b0;
        checks++; if (w_win !== 4'b0010 || w_rdata !== 7'd42) begin failures++; $display("FAIL rr_second: got %b data %0d expected 0010 42", w_win, w_rdata); end
        checks++; if (w_cyc !== 6) begin failures++; $display("FAIL rr_spacing: got %0d expected 6", w_cyc); end
        wait_done(1'b0);
        req_valid[3] = 1'b0;
        checks++; if (w_win !== 4'b1000 || w_rdata !== 7'd43) begin failures++; $display("FAIL rr_third: got %b data %0d expected 1000 43", w_win, w_rdata); end
        @(posedge clock); #1;
        checks++; if (done_cnt - d0 !== 3) begin failures++; $display("FAIL rr_done_count: got %0d expected 3", done_cnt - d0); end
    endtask

    task automatic test_invalidate();
        do_reset();
        set_req(1, 2'b11, 5'd0);
        wait_done(1'b1);
        checks++; if (w_bv !== 1 || w_bcmd !== 2'b11) begin failures++; $display("FAIL inv_bcast: got n=%0d cmd=%b expected 1 11", w_bv, w_bcmd); end
        checks++; if (w_rsp !== 0) begin failures++; $display("FAIL inv_no_rsp: got %0d expected 0", w_rsp); end
        checks++; if (w_cyc !== 3 || w_we !== 0) begin failures++; $display("FAIL inv_timing: got cyc=%0d we=%0d expected 3 0", w_cyc, w_we); end
    endtask

    task automatic test_multi_owner_and_abort();
        do_reset();
        dut.mem_q[5] = 7'd0;
        dut.mem_q[6] = 7'd55;
        set_req(0, 2'b01, 5'd5);
        snp_hit_m = 4'b0110;
        snp_data[1*DW +: DW] = 7'd11;
        snp_data[2*DW +: DW] = 7'd22;
        wait_done(1'b1);
        snp_hit_m = '0;
        checks++; if (w_rdata !== 7'd11) begin failures++; $display("FAIL multi_lowest: got %0d expected 11", w_rdata); end
        checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL multi_proto_err: got %b expected 1", proto_err); end
        checks++; if (dut.mem_q[5] !== 7'd11) begin failures++; $display("FAIL multi_mem: got %0d expected 11", dut.mem_q[5]); end
        set_req(2, 2'b01, 5'd6);
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
        end
        checks++; if (gnt !== 4'b0100 || proto_err !== 1'b1) begin failures++; $display("FAIL abort_pre: got gnt=%b perr=%b expected 0100 1", gnt, proto_err); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({gnt, bus_valid, rsp_valid, rsp_data, done_next, mem_we, proto_err} !== '0) begin
            failures++;
            $display("FAIL abort_outputs: gnt=%b bv=%b rv=%b done=%b we=%b perr=%b expected all zero", gnt, bus_valid, rsp_valid, done_next, mem_we, proto_err);
        end
        checks++; if (dut.mem_q[6] !== 7'd55 || dut.mem_q[5] !== 7'd11) begin failures++; $display("FAIL abort_mem: got %0d %0d expected 55 11", dut.mem_q[6], dut.mem_q[5]); end
        clear_inputs();
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_read_miss();
        test_owner_wb();
        test_victim_wb();
        test_round_robin();
        test_invalidate();
        test_multi_owner_and_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
